prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Sequential stage directly downstream of the 4x4 array multiplier.
- Consumes the multiplier's 8-bit product stream through a valid/ready handshake.
- Sums each burst of BURST_LEN products into an ACC_W-bit total and presents it on a held output with its own valid/ready handshake.
- Enables multiply-accumulate (dot-product) use of the combinational multiplier; in the top level the result drives uo_out/uio_out.

Parameters:
- PROD_W, 8, product input width in bits.
- ACC_W, 12, accumulator and result width in bits; must be >= PROD_W.
- BURST_LEN, 4, number of products per accumulated result; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- clear  input  1  synchronous abort: drops the partial or held result and returns to ACCUM.
- in_valid  input  1  in_product is valid this cycle.
- in_ready  output  1  block accepts in_product this cycle.
- in_product  input  PROD_W  product from the multiplier.
- out_valid  output  1  out_sum/out_ovf hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  ACC_W  accumulated sum, modulo 2^ACC_W.
- out_ovf  output  1  sticky: some addition in this burst carried out of ACC_W.

Behaviour:
- Reset (rst_n low at a clock edge): state=ACCUM, acc=0, cnt=0, ovf=0.
  - Outputs after reset: out_valid=0, in_ready=1, out_sum=0, out_ovf=0.
  - Reset overrides clear and all handshakes.
- Two states: ACCUM and HOLD. in_ready = (state==ACCUM). out_valid = (state==HOLD). Both are registered-state decodes with no combinational path from inputs.
- Accept: in_valid && in_ready at a clock edge.
  - acc <= acc + zero-extended in_product, truncated to ACC_W bits.
  - ovf <= ovf | carry-out.
  - cnt <= cnt+1.
- ACCUM -> HOLD: on the accept where cnt==BURST_LEN-1. That edge loads the final sum into acc and sets cnt to 0.
  - out_valid rises the cycle after the last accept (latency 1).
  - out_sum = acc and out_ovf = ovf, held stable while in HOLD.
- HOLD -> ACCUM: on out_ready && out_valid. acc and ovf clear to 0 on that edge.
  - in_ready returns the next cycle. Minimum one bubble cycle between bursts; no bypass.
- In HOLD, in_valid is ignored and in_product is not consumed; the upstream must hold it.
- No accept when in_valid is low. State, acc and cnt are unchanged; gaps of any length are allowed mid-burst.
- clear (when rst_n is high) takes priority over any accept or output handshake in the same cycle.
  - Next state ACCUM; acc=0, cnt=0, ovf=0.
  - The product presented that cycle is discarded.
  - A result held in HOLD is lost.
- cnt width: clog2(BURST_LEN), minimum 1 bit. It never exceeds BURST_LEN-1.
- BURST_LEN=1: every accept moves to HOLD, with out_sum = zero-extended product.
- out_sum and out_ovf hold their last value while out_valid=0; they are not cleared except by reset, clear, or the HOLD->ACCUM edge.
- The wrap-around value of out_sum is the exact low ACC_W bits of the true sum.

Test Plan:
- Reset, then feed products 15,30,45,60 back-to-back (in_valid=1 every cycle, out_ready=1).
  - Required: in_ready drops the cycle after the 4th accept; out_valid=1 with out_sum=150, out_ovf=0 for one cycle.
  - Required: in_ready=1 again on the following cycle.
- Feed 225 x4 with out_ready=0 for 5 cycles after completion.
  - Required: out_sum=900 held stable; in_ready=0 throughout; extra in_valid pulses are not consumed.
  - Required: next burst 1,1,1,1 gives out_sum=4.
- Instance with ACC_W=9, BURST_LEN=4, products 225 x4.
  - Required: out_sum=388 (900 mod 512), out_ovf=1.
  - Required: following burst 1,1,1,1 gives out_sum=4, out_ovf=0.
- Feed 10,20, then assert clear together with in_valid=1, in_product=99, then feed 5,5,5,5.
  - Required: 99 is dropped; out_sum=20, out_ovf=0.
- Feed products with in_valid toggling 1,0,0,1,0,1,1 (values 3,7,9,11).
  - Required: out_sum=30; acc is unchanged in idle cycles.
- Deassert rst_n for one cycle while in HOLD with out_sum=150.
  - Required: next cycle out_valid=0, in_ready=1, out_ovf=0.
  - Required: next burst 2,2,2,2 gives out_sum=8.

Source files
------------

// File: rtl/prod_accum.sv
// Sums each burst of BURST_LEN products from the multiplier into one ACC_W-bit result; result valid 1 cycle after the last accept.
// Backpressure: in_ready is low while a result is held; the held result waits for out_ready, then one bubble cycle before the next burst.
module prod_accum #(
   parameter int PROD_W    = 8,
   parameter int ACC_W     = 12,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [ACC_W-1:0] sum_q;
   logic             ovf_q;
   logic [ACC_W:0]   sum_ext;

   // Extra top bit of the adder is the carry-out that feeds the sticky overflow.
   assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_product);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state <= ACCUM;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         sum_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  acc <= sum_ext[ACC_W-1:0];
                  ovf <= ovf | sum_ext[ACC_W];
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= HOLD;
                     sum_q <= sum_ext[ACC_W-1:0];
                     ovf_q <= ovf | sum_ext[ACC_W];
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= '0;
                  ovf   <= 1'b0;
                  sum_q <= '0;
                  ovf_q <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   // Result outputs are separate registers so they stay put while the next burst accumulates.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign out_sum   = sum_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed table plus random traffic for prod_accum, three instances sharing one input stream.
module tb_prod_accum;

   logic       clk = 1'b0;
   logic       rst_n, clear, in_valid, out_ready;
   logic [7:0] in_product;

   logic        ir0, ov0, of0, ir1, ov1, of1, ir2, ov2, of2;
   logic [11:0] s0, s2;
   logic [8:0]  s1;

   always #5 clk = ~clk;

   prod_accum #(.PROD_W(8), .ACC_W(12), .BURST_LEN(4)) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
      .in_product(in_product), .out_valid(ov0), .out_ready(out_ready), .out_sum(s0), .out_ovf(of0));
   prod_accum #(.PROD_W(8), .ACC_W(9), .BURST_LEN(4)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
      .in_product(in_product), .out_valid(ov1), .out_ready(out_ready), .out_sum(s1), .out_ovf(of1));
   prod_accum #(.PROD_W(8), .ACC_W(12), .BURST_LEN(1)) u2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
      .in_product(in_product), .out_valid(ov2), .out_ready(out_ready), .out_sum(s2), .out_ovf(of2));

   typedef struct {
      logic       rn, clr, iv;
      logic [7:0] prod;
      logic       ordy;
      logic       e_ir, e_ov;
      int         e_sum;
      logic       e_ovf;
      int         e_sum9;
      logic       e_ovf9;
   } vec_t;

   // Reference: true running sum and product count; the modular view is taken only at burst end.
   typedef struct {
      int   tot;
      int   cnt;
      logic hold;
      int   sum;
      logic ovf;
   } mstate_t;

   vec_t    tbl[$];
   mstate_t m2;
   int      n_vec = 0;
   int      n_bad = 0;

   function automatic mstate_t step(mstate_t s, int blen, int accw, logic rn, logic clr,
                                    logic iv, logic [7:0] prod, logic ordy);
      mstate_t n = s;
      if (!rn || clr) begin
         n.tot = 0; n.cnt = 0; n.hold = 1'b0; n.sum = 0; n.ovf = 1'b0;
      end else if (!s.hold) begin
         if (iv) begin
            n.tot = s.tot + int'(prod);
            n.cnt = s.cnt + 1;
            if (n.cnt == blen) begin
               n.hold = 1'b1;
               n.sum  = n.tot % (1 << accw);
               n.ovf  = (n.tot >= (1 << accw));
               n.tot  = 0;
               n.cnt  = 0;
            end
         end
      end else if (ordy) begin
         n.hold = 1'b0; n.sum = 0; n.ovf = 1'b0;
      end
      return n;
   endfunction

   function automatic vec_t row(logic rn, logic clr, logic iv, int prod, logic ordy,
                                logic e_ir, logic e_ov, int e_sum, logic e_ovf,
                                int e_sum9, logic e_ovf9);
      vec_t v;
      v.rn = rn; v.clr = clr; v.iv = iv; v.prod = 8'(prod); v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_sum = e_sum; v.e_ovf = e_ovf;
      v.e_sum9 = e_sum9; v.e_ovf9 = e_ovf9;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got {ir,ov,ovf,sum}=%h, want %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input logic rn, input logic clr, input logic iv, input logic [7:0] prod,
                        input logic ordy);
      rst_n = rn; clear = clr; in_valid = iv; in_product = prod; out_ready = ordy;
      m2 = step(m2, 1, 12, rn, clr, iv, prod, ordy);
      @(posedge clk);
      #1;
   endtask

   task automatic check_u2(input int idx);
      cmp("blen1", idx, {ir2, ov2, of2, 1'b0, s2},
          {~m2.hold, m2.hold, m2.ovf, 1'b0, 12'(m2.sum)});
   endtask

   mstate_t m0, m1;

   initial begin
      m0 = '{0, 0, 1'b0, 0, 1'b0};
      m1 = m0;
      m2 = m0;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;

      // rn clr iv prod ordy | ir ov sum ovf sum9 ovf9
      tbl.push_back(row(0,0,0,  0,0, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 15,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 30,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 45,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 60,1, 0,1,150,0,150,0));
      tbl.push_back(row(1,0,1, 77,1, 1,0,  0,0,  0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(row(1,0,1,225,0, 1,0,0,0,0,0));
      tbl.push_back(row(1,0,1,225,0, 0,1,900,0,388,1));
      for (int i = 0; i < 5; i++) tbl.push_back(row(1,0,1,5,0, 0,1,900,0,388,1));
      tbl.push_back(row(1,0,0,  0,1, 1,0,  0,0,  0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(row(1,0,1,1,1, 1,0,0,0,0,0));
      tbl.push_back(row(1,0,1,  1,1, 0,1,  4,0,  4,0));
      tbl.push_back(row(1,0,0,  0,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 10,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 20,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,1,1, 99,1, 1,0,  0,0,  0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(row(1,0,1,5,1, 1,0,0,0,0,0));
      tbl.push_back(row(1,0,1,  5,1, 0,1, 20,0, 20,0));
      tbl.push_back(row(1,0,0,  0,1, 1,0,  0,0,  0,0));
      // in_valid pattern 1,0,0,1,0,1,1 carrying 3,7,9,11; idle cycles present junk data
      tbl.push_back(row(1,0,1,  3,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,0, 50,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,0, 60,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1,  7,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,0, 70,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1,  9,1, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 11,1, 0,1, 30,0, 30,0));
      tbl.push_back(row(1,0,0,  0,1, 1,0,  0,0,  0,0));
      // reset while holding 150
      tbl.push_back(row(1,0,1, 15,0, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 30,0, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 45,0, 1,0,  0,0,  0,0));
      tbl.push_back(row(1,0,1, 60,0, 0,1,150,0,150,0));
      tbl.push_back(row(0,0,0,  0,0, 1,0,  0,0,  0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(row(1,0,1,2,0, 1,0,0,0,0,0));
      tbl.push_back(row(1,0,1,  2,0, 0,1,  8,0,  8,0));
      tbl.push_back(row(1,0,0,  0,1, 1,0,  0,0,  0,0));

      foreach (tbl[i]) begin
         apply(tbl[i].rn, tbl[i].clr, tbl[i].iv, tbl[i].prod, tbl[i].ordy);
         cmp("acc12", i, {ir0, ov0, of0, 1'b0, s0},
             {tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_ovf, 1'b0, 12'(tbl[i].e_sum)});
         cmp("acc9", i, {ir1, ov1, of1, 4'b0, s1},
             {tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_ovf9, 4'b0, 9'(tbl[i].e_sum9)});
         check_u2(i);
      end

      // Random traffic against the burst-level model.
      apply(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      m0 = '{0, 0, 1'b0, 0, 1'b0};
      m1 = m0;
      for (int c = 0; c < 600; c++) begin
         logic       rn, clr, iv, ordy;
         logic [7:0] p;
         rn   = ($urandom_range(0, 79) != 0);
         clr  = ($urandom_range(0, 29) == 0);
         iv   = ($urandom_range(0, 2) != 0);
         ordy = ($urandom_range(0, 1) != 0);
         p    = 8'($urandom_range(0, 255));
         m0 = step(m0, 4, 12, rn, clr, iv, p, ordy);
         m1 = step(m1, 4, 9, rn, clr, iv, p, ordy);
         apply(rn, clr, iv, p, ordy);
         cmp("rnd12", c, {ir0, ov0, of0, 1'b0, s0},
             {~m0.hold, m0.hold, m0.ovf, 1'b0, 12'(m0.sum)});
         cmp("rnd9", c, {ir1, ov1, of1, 4'b0, s1},
             {~m1.hold, m1.hold, m1.ovf, 4'b0, 9'(m1.sum)});
         check_u2(c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
